// File: rtl/ysyx22041405_lsu_if.sv
// LSU bus bundle: EXU-side request, memory port and WBU-side writeback.
interface ysyx22041405_lsu_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned STRB_W = WIDTH / 8;

  // EXU side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_addr;
  logic [WIDTH-1:0] in_wdata;
  logic             in_ld;
  logic             in_st;
  logic [1:0]       in_size;
  logic             in_unsigned;
  logic [4:0]       in_rd;

  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_rdata;

  // WBU side
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd;
  logic [WIDTH-1:0] out_wdata;
  logic             out_wen;
  logic             out_exc;

  // LSU view
  modport slave (
    input  in_valid, in_addr, in_wdata, in_ld, in_st, in_size, in_unsigned, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata,
    output out_valid, out_rd, out_wdata, out_wen, out_exc,
    input  out_ready
  );

  // environment view (EXU, memory and WBU together)
  modport master (
    output in_valid, in_addr, in_wdata, in_ld, in_st, in_size, in_unsigned, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata,
    input  out_valid, out_rd, out_wdata, out_wen, out_exc,
    output out_ready
  );
endinterface

// File: rtl/ysyx22041405_lsu.sv
// Load/store unit: accepts one op, optionally runs one memory access, then
// holds the writeback bundle until the WBU takes it. All outputs registered.
module ysyx22041405_lsu #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  ysyx22041405_lsu_if.slave bus
);
  localparam int unsigned STRB_W = WIDTH / 8;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t state, state_d;

  logic              in_ready_q,  in_ready_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [WIDTH-1:0]  mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              out_valid_q, out_valid_d;
  logic [RD_W-1:0]   out_rd_q,    out_rd_d;
  logic [WIDTH-1:0]  out_wdata_q, out_wdata_d;
  logic              out_wen_q,   out_wen_d;
  logic              out_exc_q,   out_exc_d;

  // latched op attributes needed to align the load data
  logic              ld_q,   ld_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q,  off_d;
  logic              uns_q,  uns_d;

  logic              is_mem;
  logic              misalign;
  logic              is_exc;
  logic [WIDTH-1:0]  st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [WIDTH-1:0]  ld_shift;
  logic [WIDTH-1:0]  ld_data;

  // classify the incoming op (illegal size / misalignment / ld+st conflict)
  always_comb begin
    is_mem   = bus.in_ld | bus.in_st;
    misalign = 1'b0;
    unique case (bus.in_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.in_addr[0];
      2'b10:   misalign = |bus.in_addr[1:0];
      default: misalign = 1'b1;
    endcase
    is_exc = is_mem & ((bus.in_ld & bus.in_st) | misalign);
  end

  // store data lane replication and byte strobes
  always_comb begin
    st_wdata = bus.in_wdata;
    st_wstrb = {STRB_W{1'b1}};
    unique case (bus.in_size)
      2'b00: begin
        st_wdata = {(WIDTH/8){bus.in_wdata[7:0]}};
        st_wstrb = STRB_W'(4'b0001) << bus.in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {(WIDTH/16){bus.in_wdata[15:0]}};
        st_wstrb = STRB_W'(4'b0011) << bus.in_addr[1:0];
      end
      default: begin
        st_wdata = bus.in_wdata;
        st_wstrb = {STRB_W{1'b1}};
      end
    endcase
  end

  // load data alignment and sign/zero extension
  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   ld_data = uns_q ? WIDTH'(ld_shift[7:0])
                               : {{(WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = uns_q ? WIDTH'(ld_shift[15:0])
                               : {{(WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // next state and next register values
  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_wdata_d = out_wdata_q;
    out_wen_d   = out_wen_q;
    out_exc_d   = out_exc_q;
    ld_d        = ld_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;

    unique case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          out_rd_d    = bus.in_rd;
          ld_d        = bus.in_ld;
          size_d      = bus.in_size;
          off_d       = bus.in_addr[1:0];
          uns_d       = bus.in_unsigned;
          out_exc_d   = 1'b0;
          out_wen_d   = 1'b0;
          out_wdata_d = '0;
          if (!is_mem) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_wdata_d = bus.in_addr;
            out_wen_d   = |bus.in_rd;
          end else if (is_exc) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_exc_d   = 1'b1;
          end else begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.in_st;
            mem_addr_d  = {bus.in_addr[WIDTH-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = bus.in_st ? st_wstrb : '0;
          end
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_wdata_d = ld_q ? ld_data : '0;
          out_wen_d   = ld_q & (|out_rd_q);
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // output and op-attribute registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_wdata_q <= '0;
      out_wen_q   <= 1'b0;
      out_exc_q   <= 1'b0;
      ld_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_wdata_q <= out_wdata_d;
      out_wen_q   <= out_wen_d;
      out_exc_q   <= out_exc_d;
      ld_q        <= ld_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wdata = out_wdata_q;
  assign bus.out_wen   = out_wen_q;
  assign bus.out_exc   = out_exc_q;

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Self-checking bench for ysyx22041405_lsu: directed scenarios plus random ops
// compared against a byte-lane reference model.
module tb_ysyx22041405_lsu;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ysyx22041405_lsu_if #(.WIDTH(32)) bus ();

  ysyx22041405_lsu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observations collected while running one op
  bit          obs_timeout;
  bit          obs_mem_seen;
  bit          obs_mem_stable;
  logic [31:0] obs_mem_addr;
  logic        obs_mem_we;
  logic [31:0] obs_mem_wdata;
  logic [3:0]  obs_mem_wstrb;
  int          obs_out_cycle;
  logic [31:0] obs_out_wdata;
  logic        obs_out_wen;
  logic        obs_out_exc;
  logic [4:0]  obs_out_rd;
  bit          obs_out_stable;
  bit          obs_inready_low;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.in_addr     = $urandom;
    bus.in_wdata    = $urandom;
    bus.in_ld       = 1'($urandom_range(0, 1));
    bus.in_st       = 1'($urandom_range(0, 1));
    bus.in_size     = 2'($urandom_range(0, 3));
    bus.in_unsigned = 1'($urandom_range(0, 1));
    bus.in_rd       = 5'($urandom_range(0, 31));
  endtask

  // Drive one op through the LSU, recording what it does on each port.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int ack_dly, input int rdy_dly,
                        input logic [31:0] rdata);
    int c;
    int mem_cnt;
    int out_cnt;
    bit done;
    obs_timeout = 0; obs_mem_seen = 0; obs_mem_stable = 1; obs_out_stable = 1;
    obs_inready_low = 1; obs_out_cycle = -1;
    c = 0;
    while (bus.in_ready !== 1'b1 && c < 20) begin step(); c++; end
    if (bus.in_ready !== 1'b1) obs_timeout = 1;
    bus.in_valid = 1; bus.in_ld = ld; bus.in_st = st; bus.in_size = size;
    bus.in_unsigned = uns; bus.in_addr = addr; bus.in_wdata = wdata; bus.in_rd = rd;
    step();
    bus.in_valid = 0;
    scramble_inputs();
    c = 0; mem_cnt = 0; out_cnt = 0; done = 0;
    while (!done && c < 60) begin
      c++;
      bus.mem_ack   = 0;
      bus.mem_rdata = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready !== 1'b0) obs_inready_low = 0;
      if (bus.mem_req === 1'b1) begin
        if (!obs_mem_seen) begin
          obs_mem_seen = 1; obs_mem_addr = bus.mem_addr; obs_mem_we = bus.mem_we;
          obs_mem_wdata = bus.mem_wdata; obs_mem_wstrb = bus.mem_wstrb;
        end else if (bus.mem_addr !== obs_mem_addr || bus.mem_we !== obs_mem_we ||
                     bus.mem_wdata !== obs_mem_wdata || bus.mem_wstrb !== obs_mem_wstrb) begin
          obs_mem_stable = 0;
        end
        if (mem_cnt == ack_dly) begin bus.mem_ack = 1; bus.mem_rdata = rdata; end
        mem_cnt++;
      end
      if (bus.out_valid === 1'b1) begin
        bus.mem_ack = 1'($urandom_range(0, 1));
        if (out_cnt == 0) begin
          obs_out_cycle = c; obs_out_wdata = bus.out_wdata; obs_out_wen = bus.out_wen;
          obs_out_exc = bus.out_exc; obs_out_rd = bus.out_rd;
        end else if (bus.out_wdata !== obs_out_wdata || bus.out_wen !== obs_out_wen ||
                     bus.out_exc !== obs_out_exc || bus.out_rd !== obs_out_rd) begin
          obs_out_stable = 0;
        end
        if (out_cnt >= rdy_dly) begin bus.out_ready = 1; done = 1; end
        else bus.out_ready = 0;
        out_cnt++;
      end
      step();
    end
    if (!done) obs_timeout = 1;
    bus.out_ready = 0;
    bus.mem_ack   = 0;
  endtask

  // Reference model working on byte lanes with plain arithmetic.
  task automatic model(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [4:0] rd,
                       output bit e_exc, output bit e_mem, output logic [31:0] e_maddr,
                       output logic [31:0] e_mwdata, output logic [3:0] e_wstrb,
                       output logic [31:0] e_out, output bit e_wen);
    int n;
    int off;
    longint v;
    longint lane;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    e_exc = (ld || st) && ((ld && st) || size == 2'd3 || (addr % n) != 0);
    e_mem = (ld || st) && !e_exc;
    e_maddr  = addr - 32'(off);
    e_mwdata = 0;
    e_wstrb  = 0;
    e_out    = 0;
    e_wen    = 0;
    if (!ld && !st) begin
      e_out = addr;
      e_wen = (rd != 0);
    end else if (e_mem && st) begin
      for (int i = 0; i < 4; i++) begin
        lane = (longint'(wdata) >> (8 * (i % n))) % 256;
        e_mwdata = e_mwdata + 32'(lane * (longint'(1) << (8 * i)));
        e_wstrb[i] = (i >= off) && (i < off + n);
      end
    end else if (e_mem && ld) begin
      v = 0;
      for (int b = 0; b < n; b++) begin
        lane = (longint'(rdata) >> (8 * (off + b))) % 256;
        v = v + lane * (longint'(1) << (8 * b));
      end
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e_out = 32'(v);
      e_wen = (rd != 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.in_valid = 1; bus.mem_ack = 1; bus.mem_rdata = $urandom; bus.out_ready = 1;
    scramble_inputs();
    repeat (3) step();
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
    n_tests++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 6'b0) begin n_fail++; $display("FAIL rst_mem_ctl: got %b exp 0", {bus.mem_req, bus.mem_we, bus.mem_wstrb}); end
    n_tests++; if ({bus.mem_addr, bus.mem_wdata} !== 64'b0) begin n_fail++; $display("FAIL rst_mem_data: got %h exp 0", {bus.mem_addr, bus.mem_wdata}); end
    n_tests++; if ({bus.out_valid, bus.out_wen, bus.out_exc, bus.out_rd, bus.out_wdata} !== 40'b0) begin n_fail++; $display("FAIL rst_out: got %h exp 0", {bus.out_valid, bus.out_wen, bus.out_exc, bus.out_rd, bus.out_wdata}); end
    bus.in_valid = 0; bus.mem_ack = 0; bus.out_ready = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_alu();
    run_op(0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
    n_tests++; if (obs_timeout || obs_out_cycle != 1) begin n_fail++; $display("FAIL alu_latency: got %0d exp 1 (timeout=%0d)", obs_out_cycle, obs_timeout); end
    n_tests++; if (obs_out_wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_wdata: got %h exp 00001234", obs_out_wdata); end
    n_tests++; if (obs_out_wen !== 1'b1 || obs_out_exc !== 1'b0 || obs_out_rd !== 5'd5) begin n_fail++; $display("FAIL alu_ctl: got wen=%b exc=%b rd=%0d exp 1 0 5", obs_out_wen, obs_out_exc, obs_out_rd); end
    n_tests++; if (obs_mem_seen) begin n_fail++; $display("FAIL alu_no_mem: got 1 exp 0"); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_throughput: got in_ready=%b exp 1", bus.in_ready); end
  endtask

  task automatic test_load_byte();
    run_op(1, 0, 2'd0, 0, 32'h8000_0003, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
    n_tests++; if (obs_timeout || obs_out_cycle != 2) begin n_fail++; $display("FAIL lb_latency: got %0d exp 2 (timeout=%0d)", obs_out_cycle, obs_timeout); end
    n_tests++; if (obs_mem_addr !== 32'h8000_0000 || obs_mem_we !== 1'b0 || obs_mem_wstrb !== 4'b0) begin n_fail++; $display("FAIL lb_req: got %h we=%b strb=%b exp 80000000 0 0000", obs_mem_addr, obs_mem_we, obs_mem_wstrb); end
    n_tests++; if (obs_out_wdata !== 32'hFFFF_FF80 || obs_out_wen !== 1'b1) begin n_fail++; $display("FAIL lb_signed: got %h wen=%b exp ffffff80 1", obs_out_wdata, obs_out_wen); end
    run_op(1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
    n_tests++; if (obs_out_wdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_unsigned: got %h exp 00000080", obs_out_wdata); end
  endtask

  task automatic test_store_half();
    run_op(0, 1, 2'd1, 0, 32'h8000_0002, 32'h0000_BEEF, 5'd9, 0, 0, 32'h0);
    n_tests++; if (!obs_mem_seen || obs_mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sh_addr: got %h exp 80000000", obs_mem_addr); end
    n_tests++; if (obs_mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h exp beefbeef", obs_mem_wdata); end
    n_tests++; if (obs_mem_wstrb !== 4'b1100 || obs_mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_strb: got %b we=%b exp 1100 1", obs_mem_wstrb, obs_mem_we); end
    n_tests++; if (obs_timeout || obs_out_wen !== 1'b0 || obs_out_exc !== 1'b0) begin n_fail++; $display("FAIL sh_retire: got wen=%b exc=%b exp 0 0", obs_out_wen, obs_out_exc); end
  endtask

  task automatic test_misaligned();
    run_op(1, 0, 2'd2, 0, 32'h8000_0001, 32'h0, 5'd3, 0, 0, 32'h0);
    n_tests++; if (obs_mem_seen) begin n_fail++; $display("FAIL mis_no_req: got mem_req=1 exp 0"); end
    n_tests++; if (obs_timeout || obs_out_exc !== 1'b1 || obs_out_wen !== 1'b0) begin n_fail++; $display("FAIL mis_exc: got exc=%b wen=%b exp 1 0", obs_out_exc, obs_out_wen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd_val;
    rd_val = $urandom;
    run_op(1, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 5'd12, 3, 2, rd_val);
    n_tests++; if (!obs_mem_stable) begin n_fail++; $display("FAIL bp_mem_stable: got unstable exp stable"); end
    n_tests++; if (!obs_out_stable) begin n_fail++; $display("FAIL bp_out_stable: got unstable exp stable"); end
    n_tests++; if (!obs_inready_low) begin n_fail++; $display("FAIL bp_in_ready: got 1 while busy exp 0"); end
    n_tests++; if (obs_timeout || obs_out_cycle != 5 || obs_out_wdata !== rd_val) begin n_fail++; $display("FAIL bp_result: got cyc=%0d %h exp 5 %h", obs_out_cycle, obs_out_wdata, rd_val); end
  endtask

  task automatic test_reset_in_mem();
    int c;
    c = 0;
    while (bus.in_ready !== 1'b1 && c < 20) begin step(); c++; end
    bus.in_valid = 1; bus.in_ld = 1; bus.in_st = 0; bus.in_size = 2'd2;
    bus.in_unsigned = 0; bus.in_addr = 32'h8000_0020; bus.in_rd = 5'd4;
    step();
    bus.in_valid = 0;
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rim_req_up: got %b exp 1", bus.mem_req); end
    #2 rst_n = 0;
    #1;
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rim_async_drop: got %b exp 0", bus.mem_req); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    bus.mem_ack = 1; bus.mem_rdata = $urandom;
    step();
    step();
    bus.mem_ack = 0;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rim_stale_ack: got out_valid=%b mem_req=%b exp 0 0", bus.out_valid, bus.mem_req); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rim_idle: got in_ready=%b exp 1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic        ld, st, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, e_maddr, e_mwdata, e_out;
    logic [3:0]  e_wstrb;
    logic [4:0]  rd;
    bit          e_exc, e_mem, e_wen;
    int          r, ack_dly, rdy_dly, exp_cyc;
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 7));
      ld = (r >= 2 && r <= 4) || r == 7;
      st = (r >= 5);
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = (size == 2'd0) ? addr[1:0] : (size == 2'd1) ? {addr[1], 1'b0} : 2'b00;
      wdata = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31));
      ack_dly = int'($urandom_range(0, 3));
      rdy_dly = int'($urandom_range(0, 2));
      model(ld, st, size, uns, addr, wdata, rdata, rd, e_exc, e_mem, e_maddr, e_mwdata, e_wstrb, e_out, e_wen);
      exp_cyc = e_mem ? ack_dly + 2 : 1;
      run_op(ld, st, size, uns, addr, wdata, rd, ack_dly, rdy_dly, rdata);
      n_tests++; if (obs_timeout || obs_out_cycle != exp_cyc) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d exp %0d (ld=%b st=%b size=%0d addr=%h)", k, obs_out_cycle, exp_cyc, ld, st, size, addr); end
      n_tests++; if (obs_mem_seen != e_mem) begin n_fail++; $display("FAIL rnd%0d_mem_req: got %0d exp %0d", k, obs_mem_seen, e_mem); end
      if (e_mem) begin
        n_tests++; if (obs_mem_addr !== e_maddr || obs_mem_we !== st || obs_mem_wstrb !== e_wstrb) begin n_fail++; $display("FAIL rnd%0d_mem_ctl: got %h %b %b exp %h %b %b", k, obs_mem_addr, obs_mem_we, obs_mem_wstrb, e_maddr, st, e_wstrb); end
        if (st) begin
          n_tests++; if (obs_mem_wdata !== e_mwdata) begin n_fail++; $display("FAIL rnd%0d_mem_wdata: got %h exp %h", k, obs_mem_wdata, e_mwdata); end
        end
        n_tests++; if (!obs_mem_stable) begin n_fail++; $display("FAIL rnd%0d_mem_stable: got unstable exp stable", k); end
      end
      n_tests++; if (obs_out_exc !== e_exc || obs_out_wen !== e_wen || obs_out_rd !== rd) begin n_fail++; $display("FAIL rnd%0d_out_ctl: got exc=%b wen=%b rd=%0d exp %b %b %0d", k, obs_out_exc, obs_out_wen, obs_out_rd, e_exc, e_wen, rd); end
      if ((!ld && !st) || (ld && e_mem)) begin
        n_tests++; if (obs_out_wdata !== e_out) begin n_fail++; $display("FAIL rnd%0d_out_wdata: got %h exp %h", k, obs_out_wdata, e_out); end
      end
      n_tests++; if (!obs_out_stable || !obs_inready_low) begin n_fail++; $display("FAIL rnd%0d_hold: got out_stable=%0d in_ready_low=%0d exp 1 1", k, obs_out_stable, obs_inready_low); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.in_valid = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.out_ready = 0;
    scramble_inputs();
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_backpressure();
    test_reset_in_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
